transmission_mult_pipe: RTL and testbench
=========================================

TRANSMISSION_MULT_PIPE -- requirements
Module: transmission_mult_pipe

Interface
REQ-001 SHALL have parameter CH, 3, number of colour channels.
REQ-002 SHALL have parameter DW, 8, pixel channel width (unsigned integer).
REQ-003 SHALL have parameter IW, 14, inverse atmospheric light width, ω/Ac in Q0.IW.
REQ-004 SHALL have parameter OF, 10, output fraction bits.
REQ-005 SHALL have parameter T0, 102, transmission floor (Q1.OF; 102 ≈ 0.1).
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-007 SHALL have ports: s_valid in 1, s_ready out 1, s_sof in 1 (first pixel of frame), s_data in CH*DW (channel c at bits [c*DW +: DW]).
REQ-008 SHALL have ports: inv_wr in 1, inv_data in CH*IW (per-channel ω/Ac, same packing as s_data).
REQ-009 SHALL have ports: m_valid out 1, m_ready in 1, m_sof out 1, m_min out OF (ω·min(Pc/Ac)), m_trans out OF+1 (t, Q1.OF).

Function
REQ-010 SHALL hold pending and active inverse registers (CH×IW each); inv_wr=1 loads pending from inv_data.
REQ-011 SHALL copy pending to active when a beat with s_sof=1 is accepted; that beat and all following beats use the new values.
REQ-012 SHALL use pending as updated in the same cycle when inv_wr and the sof beat acceptance coincide.
REQ-013 SHALL accept a beat when s_valid && s_ready.
REQ-014 SHALL drive s_ready = !m_valid || m_ready; all stages advance together when s_ready=1, and hold when s_ready=0.
REQ-015 SHALL not collapse bubbles; an empty stage shifts as invalid.
REQ-016 Stage 1 SHALL register P_c = Pc × Inv_c, exact width DW+IW, for each channel.
REQ-017 Stage 2 SHALL compute Q_c = P_c >> (IW−OF), truncating.
REQ-018 Stage 2 SHALL saturate Q_c to 2^OF−1 when Q_c ≥ 2^OF; modulo wrap is forbidden.
REQ-019 Stage 2 SHALL register the minimum over channels as m_min.
REQ-020 Stage 3 SHALL compute t = 2^OF − min and register max(t, T0) as m_trans.
REQ-021 SHALL have latency 3 accepted-cycles, input beat to m_valid, with no stall.
REQ-022 SHALL throughput 1 beat/cycle.
REQ-023 SHALL carry sof alongside the data to m_sof.
REQ-024 SHALL keep m_* stable while m_valid && !m_ready.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, clear: all stage valids, m_valid, m_sof, m_min, m_trans, and the pending and active inverse registers.
REQ-026 SHALL drive s_ready=1 during and after reset.
REQ-027 SHALL discard in-flight beats on reset mid-operation, with no output produced for them.

Structure
REQ-028 SHALL place default parameter values and the T0 constant in the shared dehaze package, shared with the airlight and filter blocks.
REQ-029 SHALL use one sub-module, te_chan_scale: multiply, shift and saturate for one channel, instantiated CH times.
REQ-030 SHALL implement the channel min and the transmission clamp in the top level.

Verification (defaults; inv_wr {78,78,78} then sof beat)
REQ-031 SHALL cover: s_data {100,150,200} → m_min=487, m_trans=537, m_valid exactly 3 cycles after acceptance.
REQ-032 SHALL cover: s_data {255,255,255}, inv {100,100,100} → every Q=1593 saturates to 1023, so m_min=1023; raw t=1, clamped to m_trans=102.
REQ-033 SHALL cover: s_data {0,50,50}, inv 78 → m_min=0, m_trans=1024.
REQ-034 SHALL cover: inv_wr {156,…} mid-frame, then a non-sof beat {100,…} → still 487; next sof beat {100,…} → 975.
REQ-035 SHALL cover: a random valid stream with random m_ready low periods → no loss or duplication, order preserved, outputs stable while stalled, s_ready tracks REQ-014.
REQ-036 SHALL cover: rst asserted with 3 beats in flight → m_valid=0 the next cycle; no stale output after release; active inverse = 0, so a beat yields m_trans=1024.

Source files
------------

// File: rtl/dehaze_pkg.sv
// rtl/dehaze_pkg.sv - shared dehaze defaults used by airlight, filter and transmission blocks
package dehaze_pkg;
    localparam int DEF_CH = 3;
    localparam int DEF_DW = 8;
    localparam int DEF_IW = 14;
    localparam int DEF_OF = 10;
    // Transmission floor in Q1.OF, about 0.1 at OF=10
    localparam int DEF_T0 = 102;
endpackage

// File: rtl/te_chan_scale.sv
// rtl/te_chan_scale.sv - one channel: registered Pc*inv product, then shift and saturate to Q0.OF
module te_chan_scale #(
    parameter int DW = 8,
    parameter int IW = 14,
    parameter int OF = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] pix,
    input  logic [IW-1:0] inv,
    output logic [OF-1:0] q
);
    logic [DW+IW-1:0] prod;
    logic [DW+IW-1:0] shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
        end else if (en) begin
            prod <= (DW+IW)'(pix) * (DW+IW)'(inv);
        end
    end

    // Any bit above the OF-bit fraction means the ratio reached 1.0: clamp instead of wrapping
    always_comb begin
        shifted = prod >> (IW - OF);
        if (|shifted[DW+IW-1:OF]) begin
            q = '1;
        end else begin
            q = shifted[OF-1:0];
        end
    end
endmodule

// File: rtl/transmission_mult_pipe.sv
// rtl/transmission_mult_pipe.sv - 3-stage dark-channel transmission estimate t = max(1 - w*min(Pc/Ac), t0)
module transmission_mult_pipe
    import dehaze_pkg::*;
#(
    parameter int CH = DEF_CH,
    parameter int DW = DEF_DW,
    parameter int IW = DEF_IW,
    parameter int OF = DEF_OF,
    parameter int T0 = DEF_T0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [CH*DW-1:0] s_data,
    input  logic             inv_wr,
    input  logic [CH*IW-1:0] inv_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sof,
    output logic [OF-1:0]    m_min,
    output logic [OF:0]      m_trans
);
    localparam logic [OF:0] ONE_Q = {1'b1, {OF{1'b0}}};
    localparam logic [OF:0] T0_Q  = (OF+1)'(T0);

    logic             adv;
    logic             accept;
    logic [CH*IW-1:0] inv_pending;
    logic [CH*IW-1:0] inv_active;
    logic [CH*IW-1:0] inv_sel;
    logic [CH*IW-1:0] inv_use;
    logic             v1, sof1, v2, sof2;
    logic [OF-1:0]    min2;
    logic [OF-1:0]    q [CH];
    logic [OF-1:0]    ch_min;
    logic [OF:0]      t_raw;
    logic [OF:0]      t_clamp;

    assign adv     = !m_valid || m_ready;
    assign s_ready = rst || adv;
    assign accept  = s_valid && s_ready;

    // A frame start switches to the newest pending set, including one written in the same cycle
    assign inv_sel = inv_wr ? inv_data : inv_pending;
    assign inv_use = (accept && s_sof) ? inv_sel : inv_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_pending <= '0;
            inv_active  <= '0;
        end else begin
            if (inv_wr) begin
                inv_pending <= inv_data;
            end
            if (accept && s_sof) begin
                inv_active <= inv_sel;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        te_chan_scale #(.DW(DW), .IW(IW), .OF(OF)) u_scale (
            .clk (clk),
            .rst (rst),
            .en  (adv),
            .pix (s_data[c*DW +: DW]),
            .inv (inv_use[c*IW +: IW]),
            .q   (q[c])
        );
    end

    always_comb begin
        ch_min = q[0];
        for (int c = 1; c < CH; c++) begin
            if (q[c] < ch_min) begin
                ch_min = q[c];
            end
        end
    end

    always_comb begin
        t_raw   = ONE_Q - {1'b0, min2};
        t_clamp = (t_raw < T0_Q) ? T0_Q : t_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            sof1    <= 1'b0;
            v2      <= 1'b0;
            sof2    <= 1'b0;
            min2    <= '0;
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_min   <= '0;
            m_trans <= '0;
        end else if (adv) begin
            v1      <= accept;
            sof1    <= s_sof && accept;
            v2      <= v1;
            sof2    <= sof1;
            min2    <= ch_min;
            m_valid <= v2;
            m_sof   <= sof2;
            m_min   <= min2;
            m_trans <= t_clamp;
        end
    end
endmodule

// File: tb/tb_transmission_mult_pipe.sv
// tb/tb_transmission_mult_pipe.sv - self-checking bench for transmission_mult_pipe
module tb_transmission_mult_pipe;
    localparam int CH = 3;
    localparam int DW = 8;
    localparam int IW = 14;
    localparam int OF = 10;
    localparam int T0 = 102;

    typedef struct {
        longint mn;
        longint tr;
        bit     sof;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic             s_sof;
    logic [CH*DW-1:0] s_data;
    logic             inv_wr;
    logic [CH*IW-1:0] inv_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_sof;
    logic [OF-1:0]    m_min;
    logic [OF:0]      m_trans;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    logic [CH*IW-1:0] mdl_pending;
    logic [CH*IW-1:0] mdl_active;

    transmission_mult_pipe #(.CH(CH), .DW(DW), .IW(IW), .OF(OF), .T0(T0)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_sof    (s_sof),
        .s_data   (s_data),
        .inv_wr   (inv_wr),
        .inv_data (inv_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sof    (m_sof),
        .m_min    (m_min),
        .m_trans  (m_trans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: ratio per channel, capped at just under 1.0, darkest channel, then 1 - w*min floored at t0
    function automatic exp_t model(input logic [CH*DW-1:0] d, input logic [CH*IW-1:0] inv, input bit sof);
        exp_t   e;
        longint q;
        e.mn = (1 << OF) - 1;
        for (int c = 0; c < CH; c++) begin
            q = (longint'(d[c*DW +: DW]) * longint'(inv[c*IW +: IW])) / (1 << (IW - OF));
            if (q > (1 << OF) - 1) q = (1 << OF) - 1;
            if (q < e.mn) e.mn = q;
        end
        e.tr  = (1 << OF) - e.mn;
        if (e.tr < T0) e.tr = T0;
        e.sof = sof;
        return e;
    endfunction

    function automatic logic [CH*DW-1:0] pix3(input int a, input int b, input int c);
        logic [DW-1:0] pa, pb, pc;
        pa = DW'(a);
        pb = DW'(b);
        pc = DW'(c);
        return {pc, pb, pa};
    endfunction

    function automatic logic [CH*IW-1:0] inv3(input int v);
        logic [IW-1:0] pv;
        pv = IW'(v);
        return {CH{pv}};
    endfunction

    // One clock: evaluate handshakes against the scoreboard, advance, verify stall stability
    task automatic tick();
        logic          acc, ofire, stall;
        logic          p_sof;
        logic [OF-1:0] p_min;
        logic [OF:0]   p_trans;
        exp_t          e;
        #1;
        acc     = s_valid && s_ready && !rst;
        ofire   = m_valid && m_ready && !rst;
        stall   = m_valid && !m_ready && !rst;
        p_sof   = m_sof;
        p_min   = m_min;
        p_trans = m_trans;
        if (rst) chk("s_ready_in_reset", 64'(s_ready), 64'd1);
        else     chk("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
        if (ofire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(m_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_min", 64'(m_min), 64'(e.mn));
                chk("sb_trans", 64'(m_trans), 64'(e.tr));
                chk("sb_sof", 64'(m_sof), 64'(e.sof));
            end
        end
        if (rst) begin
            exp_q.delete();
            mdl_pending = '0;
            mdl_active  = '0;
        end else begin
            if (acc && s_sof) mdl_active = inv_wr ? inv_data : mdl_pending;
            if (acc) exp_q.push_back(model(s_data, mdl_active, s_sof));
            if (inv_wr) mdl_pending = inv_data;
        end
        @(posedge clk);
        #1;
        if (stall) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_min", 64'(m_min), 64'(p_min));
            chk("stall_trans", 64'(m_trans), 64'(p_trans));
            chk("stall_sof", 64'(m_sof), 64'(p_sof));
        end
    endtask

    // Present one beat on an idle pipe, then check latency and the hand-computed result
    task automatic beat(input string tag, input logic [CH*DW-1:0] d, input bit sof,
                        input bit wr, input logic [CH*IW-1:0] inv,
                        input int exp_min, input int exp_trans);
        int n;
        s_valid  = 1'b1;
        s_data   = d;
        s_sof    = sof;
        inv_wr   = wr;
        inv_data = inv;
        m_ready  = 1'b1;
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        inv_wr  = 1'b0;
        n = 1;
        while (!m_valid && n < 6) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd3);
        chk({tag, "_min"}, 64'(m_min), 64'(exp_min));
        chk({tag, "_trans"}, 64'(m_trans), 64'(exp_trans));
        chk({tag, "_sof"}, 64'(m_sof), 64'(sof));
        tick();
    endtask

    task automatic write_inv(input logic [CH*IW-1:0] inv);
        inv_wr   = 1'b1;
        inv_data = inv;
        tick();
        inv_wr = 1'b0;
    endtask

    initial begin
        mdl_pending = '0;
        mdl_active  = '0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_sof    = 1'b0;
        s_data   = '0;
        inv_wr   = 1'b0;
        inv_data = '0;
        m_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_sof", 64'(m_sof), 64'd0);
        chk("rst_m_min", 64'(m_min), 64'd0);
        chk("rst_m_trans", 64'(m_trans), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);

        write_inv(inv3(78));
        beat("basic", pix3(100, 150, 200), 1'b1, 1'b0, '0, 487, 537);
        write_inv(inv3(100));
        beat("saturate", pix3(255, 255, 255), 1'b1, 1'b0, '0, 1023, 102);
        write_inv(inv3(78));
        beat("zero_min", pix3(0, 50, 50), 1'b1, 1'b0, '0, 0, 1024);
        write_inv(inv3(156));
        beat("midframe", pix3(100, 100, 100), 1'b0, 1'b0, '0, 487, 537);
        beat("next_sof", pix3(100, 100, 100), 1'b1, 1'b0, '0, 975, 102);
        beat("same_cycle_wr", pix3(100, 100, 100), 1'b1, 1'b1, inv3(78), 487, 537);

        for (int i = 0; i < 400; i++) begin
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data   = CH*DW'($urandom);
            s_sof    = ($urandom_range(0, 7) == 0);
            inv_wr   = ($urandom_range(0, 15) == 0);
            inv_data = {IW'($urandom), IW'($urandom_range(0, 300)), IW'($urandom_range(0, 300))};
            m_ready  = (i % 40 < 30) ? ($urandom_range(0, 3) != 0) : 1'b0;
            tick();
        end
        s_valid = 1'b0;
        inv_wr  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Three beats stuck in the pipe when reset hits; none of them may emerge
        write_inv(inv3(78));
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_sof   = (i == 0);
            s_data  = pix3(100 + i, 150, 200);
            tick();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("inflight_valid", 64'(m_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 64'(m_valid), 64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_stale", 64'(m_valid), 64'd0);
        end
        beat("post_rst", pix3(100, 150, 200), 1'b1, 1'b0, '0, 0, 1024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
